// File: rtl/bypass_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bypass_pkg: stage-entry type and default parameters for bypass_ctrl   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package bypass_pkg;

  localparam int DEF_AW       = 5;
  localparam int DEF_DEPTH    = 3;
  localparam int DEF_N_SRC    = 2;
  localparam int DEF_LOAD_LAT = 1;

  // Destination field is sized for the widest supported register file;
  // narrower instances zero-extend and leave the upper bits constant.
  localparam int MAX_AW = 8;

  typedef struct packed {
    logic              valid;
    logic              wr_en;
    logic [MAX_AW-1:0] dest;
    logic              is_load;
  } stage_entry_t;

endpackage
`default_nettype wire

// File: rtl/bypass_src_match.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bypass_src_match: youngest-wins forwarding select for one source      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module bypass_src_match
  import bypass_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int LOAD_LAT = DEF_LOAD_LAT
) (
  input  logic                     src_valid,
  input  logic [AW-1:0]            src_addr,
  input  stage_entry_t [DEPTH-1:0] stages,
  output logic [DEPTH-1:0]         sel,
  output logic                     hazard
);

  logic [MAX_AW-1:0] addr_ext;
  logic              found;

  always_comb begin
    addr_ext           = '0;
    addr_ext[AW-1:0]   = src_addr;
    sel                = '0;
    hazard             = 1'b0;
    found              = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!found && src_valid && stages[k].valid && stages[k].wr_en &&
          (stages[k].dest == addr_ext) && (addr_ext != '0)) begin
        sel[k] = 1'b1;
        // Load data is not yet available in stages younger than LOAD_LAT.
        hazard = stages[k].is_load && (k < LOAD_LAT);
        found  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bypass_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bypass_ctrl: producer-stage tracking, forwarding select and load-use  |
// | stall. Optional stall counter under BYPASS_CTRL_STATS_EN.             |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module bypass_ctrl
  import bypass_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int N_SRC    = DEF_N_SRC,
  parameter int LOAD_LAT = DEF_LOAD_LAT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   advance,
  input  logic                   flush,
  input  logic                   issue_valid,
  input  logic                   issue_wr_en,
  input  logic [AW-1:0]          issue_dest,
  input  logic                   issue_is_load,
  input  logic [N_SRC-1:0]       src_valid,
  input  logic [N_SRC*AW-1:0]    src_addr,
  output logic [N_SRC*DEPTH-1:0] byp_sel,
`ifdef BYPASS_CTRL_STATS_EN
  output logic [31:0]            stall_count,
`endif
  output logic                   stall
);

  stage_entry_t [DEPTH-1:0] stage_q;
  stage_entry_t [DEPTH-1:0] stage_d;
  stage_entry_t             issue_entry;
  logic [N_SRC-1:0]         src_hazard;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    bypass_src_match #(
      .AW       (AW),
      .DEPTH    (DEPTH),
      .LOAD_LAT (LOAD_LAT)
    ) u_match (
      .src_valid (src_valid[i]),
      .src_addr  (src_addr[i*AW +: AW]),
      .stages    (stage_q),
      .sel       (byp_sel[i*DEPTH +: DEPTH]),
      .hazard    (src_hazard[i])
    );
  end

  assign stall = |src_hazard;

  always_comb begin
    issue_entry               = '0;
    issue_entry.valid         = 1'b1;
    issue_entry.wr_en         = issue_wr_en;
    issue_entry.dest[AW-1:0]  = issue_dest;
    issue_entry.is_load       = issue_is_load;

    stage_d = stage_q;
    if (advance) begin
      for (int k = 1; k < DEPTH; k++) begin
        stage_d[k] = stage_q[k-1];
      end
      stage_d[0] = (issue_valid && !stall && !flush) ? issue_entry : '0;
    end else if (flush) begin
      stage_d[0].valid = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

`ifdef BYPASS_CTRL_STATS_EN
  logic [31:0] stall_count_q;
  logic [31:0] stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && advance && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bypass_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bypass_ctrl: directed vector table for bypass_ctrl (defaults)      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_bypass_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        advance;
  logic        flush;
  logic        issue_valid;
  logic        issue_wr_en;
  logic [4:0]  issue_dest;
  logic        issue_is_load;
  logic [1:0]  src_valid;
  logic [9:0]  src_addr;
  logic [5:0]  byp_sel;
  logic        stall;
`ifdef BYPASS_CTRL_STATS_EN
  logic [31:0] stall_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  bypass_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .advance       (advance),
    .flush         (flush),
    .issue_valid   (issue_valid),
    .issue_wr_en   (issue_wr_en),
    .issue_dest    (issue_dest),
    .issue_is_load (issue_is_load),
    .src_valid     (src_valid),
    .src_addr      (src_addr),
    .byp_sel       (byp_sel),
`ifdef BYPASS_CTRL_STATS_EN
    .stall_count   (stall_count),
`endif
    .stall         (stall)
  );

  typedef struct {
    logic       rst;
    logic       adv;
    logic       fl;
    logic       iv;
    logic       iwr;
    logic [4:0] idest;
    logic       ild;
    logic [1:0] srcv;
    logic [4:0] s0;
    logic [4:0] s1;
    logic [5:0] sel;
    logic       stl;
    int         cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic adv, logic fl, logic iv, logic iwr,
                              logic [4:0] idest, logic ild, logic [1:0] srcv,
                              logic [4:0] s0, logic [4:0] s1, logic [5:0] sel,
                              logic stl, int cnt);
    vec_t v;
    v.rst = rst; v.adv = adv; v.fl = fl; v.iv = iv; v.iwr = iwr;
    v.idest = idest; v.ild = ild; v.srcv = srcv; v.s0 = s0; v.s1 = s1;
    v.sel = sel; v.stl = stl; v.cnt = cnt;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    reset         = v.rst;
    advance       = v.adv;
    flush         = v.fl;
    issue_valid   = v.iv;
    issue_wr_en   = v.iwr;
    issue_dest    = v.idest;
    issue_is_load = v.ild;
    src_valid     = v.srcv;
    src_addr      = {v.s1, v.s0};
  endtask

  task automatic check_outputs(input string name, input logic [5:0] exp_sel,
                               input logic exp_stl, input int exp_cnt);
    checks++;
    if (byp_sel !== exp_sel) begin
      errors++;
      $display("FAIL %s byp_sel got %b expected %b", name, byp_sel, exp_sel);
    end
    checks++;
    if (stall !== exp_stl) begin
      errors++;
      $display("FAIL %s stall got %b expected %b", name, stall, exp_stl);
    end
`ifdef BYPASS_CTRL_STATS_EN
    checks++;
    if (stall_count !== 32'(exp_cnt)) begin
      errors++;
      $display("FAIL %s stall_count got %0d expected %0d", name, stall_count, exp_cnt);
    end
`else
    if (exp_cnt < 0) $display("unexpected negative count %0d", exp_cnt);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Stage state before each row's clock edge is noted on the right.
    //                rst adv fl iv iwr dest ld srcv s0  s1  sel        stl cnt
    vecs.push_back(mk(0, 1, 0, 1, 1, 5,  0, 2'b00, 0,  0,  6'b000000, 0, 0)); // r0  empty
    vecs.push_back(mk(0, 1, 0, 1, 1, 5,  0, 2'b01, 5,  0,  6'b000001, 0, 0)); // r1  add5,-,-
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 2'b10, 0,  5,  6'b001000, 0, 0)); // r2  add5,add5,-
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 2'b11, 5,  5,  6'b001001, 0, 0)); // r3
    vecs.push_back(mk(0, 1, 0, 0, 0, 0,  0, 2'b00, 0,  0,  6'b000000, 0, 0)); // r4
    vecs.push_back(mk(0, 1, 0, 1, 1, 7,  1, 2'b01, 5,  0,  6'b000010, 0, 0)); // r5  -,add5,add5
    vecs.push_back(mk(0, 1, 0, 1, 1, 9,  0, 2'b01, 7,  0,  6'b000001, 1, 0)); // r6  ld7,-,add5
    vecs.push_back(mk(0, 1, 0, 1, 1, 9,  0, 2'b01, 7,  0,  6'b000010, 0, 1)); // r7  -,ld7,-
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 2'b11, 7,  9,  6'b001100, 0, 1)); // r8  add9,-,ld7
    vecs.push_back(mk(0, 1, 0, 1, 1, 0,  1, 2'b01, 9,  0,  6'b000001, 0, 1)); // r9
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 2'b11, 0,  7,  6'b000000, 0, 1)); // r10 ld0,add9,-
    vecs.push_back(mk(0, 1, 0, 1, 0, 3,  0, 2'b01, 9,  0,  6'b000010, 0, 1)); // r11
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 2'b11, 3,  9,  6'b100000, 0, 1)); // r12 nw3,ld0,add9
    vecs.push_back(mk(0, 1, 1, 1, 1, 4,  0, 2'b00, 0,  0,  6'b000000, 0, 1)); // r13
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 2'b11, 4,  9,  6'b000000, 0, 1)); // r14 -,nw3,ld0
    vecs.push_back(mk(0, 1, 0, 1, 1, 1,  0, 2'b00, 0,  0,  6'b000000, 0, 1)); // r15
    vecs.push_back(mk(0, 1, 0, 1, 1, 2,  0, 2'b00, 0,  0,  6'b000000, 0, 1)); // r16
    vecs.push_back(mk(0, 1, 0, 1, 1, 3,  0, 2'b00, 0,  0,  6'b000000, 0, 1)); // r17
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 2'b11, 3,  1,  6'b100001, 0, 1)); // r18 a3,a2,a1
    vecs.push_back(mk(0, 0, 1, 0, 0, 0,  0, 2'b11, 2,  3,  6'b001010, 0, 1)); // r19 flush hold
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 2'b11, 2,  3,  6'b000010, 0, 1)); // r20 -,a2,a1
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 2'b11, 1,  2,  6'b010100, 0, 1)); // r21
    vecs.push_back(mk(0, 1, 0, 1, 1, 6,  1, 2'b00, 0,  0,  6'b000000, 0, 1)); // r22
    vecs.push_back(mk(1, 1, 0, 1, 1, 8,  0, 2'b01, 6,  0,  6'b000001, 1, 1)); // r23 reset mid-stall
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 2'b11, 6,  2,  6'b000000, 0, 0)); // r24 empty
    vecs.push_back(mk(0, 1, 0, 1, 1, 6,  1, 2'b00, 0,  0,  6'b000000, 0, 0)); // r25
    vecs.push_back(mk(0, 1, 1, 1, 1, 8,  0, 2'b01, 6,  0,  6'b000001, 1, 0)); // r26 flush+stall
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 2'b11, 6,  8,  6'b000010, 0, 1)); // r27 -,ld6,-
    vecs.push_back(mk(0, 1, 0, 1, 1, 10, 1, 2'b00, 0,  0,  6'b000000, 0, 1)); // r28
    vecs.push_back(mk(0, 0, 0, 1, 1, 11, 0, 2'b01, 10, 0,  6'b000001, 1, 1)); // r29 stall, no adv
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 2'b10, 0,  6,  6'b100000, 0, 1)); // r30 ld10,-,ld6

    // Reset for two edges, then confirm a clean, non-forwarding state.
    drive(mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 6'b0, 0, 0));
    repeat (2) @(posedge clock);
    @(negedge clock);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 2'b11, 5, 7, 6'b0, 0, 0));
    #1;
    check_outputs("after_reset", 6'b000000, 1'b0, 0);

    foreach (vecs[i]) begin
      @(negedge clock);
      drive(vecs[i]);
      #1;
      check_outputs($sformatf("row%0d", i), vecs[i].sel, vecs[i].stl, vecs[i].cnt);
    end

    // Reset with producers still in the pipe clears every select and the counter.
    @(negedge clock);
    drive(mk(1, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 6'b0, 0, 0));
    @(negedge clock);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 2'b11, 10, 6, 6'b0, 0, 0));
    #1;
    check_outputs("final_reset", 6'b000000, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bypass_ctrl.md
BYPASS_CTRL -- requirements
Module: bypass_ctrl

Interface
REQ-001 Parameter AW, default 5, register-address width.
REQ-002 Parameter DEPTH, default 3, tracked producer stages after decode; stage 0 = execute (youngest), stage DEPTH-1 = writeback (oldest).
REQ-003 Parameter N_SRC, default 2, source operands per decoded instruction.
REQ-004 Parameter LOAD_LAT, default 1, lowest stage index whose load result is forwardable; range 1..DEPTH-1.
REQ-005 clock  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 advance  in  1  pipeline advances this cycle.
REQ-008 flush  in  1  kill instruction entering or sitting in stage 0.
REQ-009 issue_valid  in  1  decode-stage instruction present.
REQ-010 issue_wr_en  in  1  decode instruction writes a register (rd or rt destination already resolved).
REQ-011 issue_dest  in  AW  decode instruction destination.
REQ-012 issue_is_load  in  1  decode instruction is a load.
REQ-013 src_valid  in  N_SRC  per-source read enable.
REQ-014 src_addr  in  N_SRC*AW  per-source register address, source i at bits [i*AW +: AW].
REQ-015 byp_sel  out  N_SRC*DEPTH  per-source one-hot forwarding select, bit k = stage k; all-zero = use register file.
REQ-016 stall  out  1  load-use hazard; decode must hold.
REQ-017 stall_count  out  32  stall-cycle counter (only with BYPASS_CTRL_STATS_EN).

Function
REQ-018 Per-stage entry SHALL hold valid, wr_en, dest, is_load.
REQ-019 Stage k SHALL match source i when src_valid[i], entry valid, wr_en, dest==src_addr[i], dest!=0.
REQ-020 byp_sel for source i SHALL select only the lowest-index matching stage (youngest wins); all others zero.
REQ-021 stall SHALL be 1 when any source's selected stage k holds a load with k<LOAD_LAT; byp_sel SHALL still report that stage.
REQ-022 stall and byp_sel SHALL be combinational from current stage state and decode inputs, zero latency.
REQ-023 On advance=1: stage k+1 <= stage k for all k; stage 0 <= decode entry if issue_valid & ~stall & ~flush, else bubble (valid=0).
REQ-024 On advance=0: all stages SHALL hold, except flush=1 invalidates stage 0 in place.
REQ-025 flush and stall together with advance=1: stage 0 SHALL receive bubble, older stages shift.
REQ-026 Entry leaving stage DEPTH-1 SHALL be discarded; no wrap-around.
REQ-027 Writes to register 0 SHALL never forward or stall.

Reset
REQ-028 reset=1 at an edge SHALL clear every stage valid bit, overriding advance/flush.
REQ-029 After reset byp_sel=0, stall=0, stall_count=0; reset mid-stall SHALL drop stall next cycle unless decode inputs recreate the hazard against empty stages (impossible, so stall=0).

Configuration
REQ-030 Macro BYPASS_CTRL_STATS_EN defined: stall_count SHALL increment by 1 each cycle stall=1 & advance=1, saturating at 32'hFFFFFFFF.
REQ-031 Macro undefined: stall_count port SHALL be absent and no counter logic built.

Structure
REQ-032 Package bypass_pkg SHALL hold the stage-entry typedef (valid, wr_en, dest, is_load) and default-parameter constants.
REQ-033 Sub-module bypass_src_match SHALL compare one source against all DEPTH stages and produce its priority one-hot select and load-hazard bit; bypass_ctrl instantiates N_SRC copies.

Verification
REQ-034 Defaults; issue add dest=5, advance; next decode src0=5 -> byp_sel src0=3'b001, stall=0.
REQ-035 Same dest=5 in stages 0 and 1, src1=5 -> src1 select 3'b001 only.
REQ-036 Load dest=7 in stage 0, src0=7, advance=1 -> stall=1, stage 0 gets bubble; next cycle load in stage 1 -> stall=0, select 3'b010; stall_count=1 with macro.
REQ-037 Stage entry dest=0 wr_en=1, src0=0 -> byp_sel=0, stall=0.
REQ-038 Stages full, flush=1 advance=0 -> stage 0 invalid, stages 1..2 unchanged; then reset=1 -> all selects 0, stall_count=0.
